// File: rtl/trap_ctrl.sv
// trap_ctrl: commit-stage exception and MRET sequencer.
// Picks the highest-priority exception of the committing instruction, hands the
// trap values to the CSR file for one cycle, redirects the PC, and then holds the
// pipeline flushed for FLUSH_CYCLES cycles. While flushing, all new requests are dropped.
module trap_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            instr_v_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] badaddr_i,
  input  logic            instr_misaligned_i,
  input  logic            illegal_i,
  input  logic            ebreak_i,
  input  logic            ecall_i,
  input  logic            load_misaligned_i,
  input  logic            store_misaligned_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] mtvec_q_i,
  input  logic [XLEN-1:0] mepc_q_i,
  output logic            exception_o,
  output logic [XLEN-1:0] mcause_o,
  output logic [XLEN-1:0] mtval_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            branch_v_o,
  output logic [XLEN-1:0] branch_adr_o,
  output logic            flush_o,
  output logic            busy_o,
  output logic [31:0]     trap_cnt_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Exception cause codes (interrupt bit is always 0 here).
  localparam logic [4:0] CAUSE_INSTR_MISALIGNED = 5'd0;
  localparam logic [4:0] CAUSE_ILLEGAL          = 5'd2;
  localparam logic [4:0] CAUSE_EBREAK           = 5'd3;
  localparam logic [4:0] CAUSE_LOAD_MISALIGNED  = 5'd4;
  localparam logic [4:0] CAUSE_STORE_MISALIGNED = 5'd6;
  localparam logic [4:0] CAUSE_ECALL            = 5'd11;

  // Counter reload: the first flush cycle is the one right after acceptance,
  // so the counter starts at FLUSH_CYCLES-1 and the sequence ends when it hits 0.
  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            exception_q, exception_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic            branch_v_q, branch_v_d;
  logic [XLEN-1:0] branch_adr_q, branch_adr_d;
  logic            flush_q, flush_d;
  logic            busy_q, busy_d;
  logic [31:0]     trap_cnt_q, trap_cnt_d;

  logic            any_exc;
  logic            trap_req;
  logic            mret_req;
  logic [4:0]      cause_sel;
  logic [XLEN-1:0] tval_sel;

  // Cause/tval selection by fixed priority; only the winning cause is recorded.
  always_comb begin
    any_exc   = instr_misaligned_i | illegal_i | ebreak_i | ecall_i
              | load_misaligned_i | store_misaligned_i;
    cause_sel = CAUSE_STORE_MISALIGNED;
    tval_sel  = badaddr_i;
    if (instr_misaligned_i) begin
      cause_sel = CAUSE_INSTR_MISALIGNED;
      tval_sel  = badaddr_i;
    end else if (illegal_i) begin
      cause_sel = CAUSE_ILLEGAL;
      tval_sel  = XLEN'(instr_i);
    end else if (ebreak_i) begin
      cause_sel = CAUSE_EBREAK;
      tval_sel  = '0;
    end else if (ecall_i) begin
      cause_sel = CAUSE_ECALL;
      tval_sel  = '0;
    end else if (load_misaligned_i) begin
      cause_sel = CAUSE_LOAD_MISALIGNED;
      tval_sel  = badaddr_i;
    end
    // An exception always wins over MRET on the same instruction.
    trap_req = instr_v_i & any_exc;
    mret_req = instr_v_i & mret_i & ~any_exc;
  end

  // Next-state logic: accept requests only in IDLE, then count down the flush.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    exception_d  = 1'b0;
    branch_v_d   = 1'b0;
    mcause_d     = mcause_q;
    mtval_d      = mtval_q;
    mepc_d       = mepc_q;
    branch_adr_d = branch_adr_q;
    flush_d      = flush_q;
    busy_d       = busy_q;
    trap_cnt_d   = trap_cnt_q;

    unique case (state_q)
      IDLE: begin
        flush_d = 1'b0;
        busy_d  = 1'b0;
        if (trap_req) begin
          state_d      = FLUSH;
          cnt_d        = FLUSH_RELOAD;
          exception_d  = 1'b1;
          branch_v_d   = 1'b1;
          branch_adr_d = {mtvec_q_i[XLEN-1:2], 2'b00};
          mcause_d     = XLEN'(cause_sel);
          mtval_d      = tval_sel;
          mepc_d       = pc_i;
          flush_d      = 1'b1;
          busy_d       = 1'b1;
          trap_cnt_d   = trap_cnt_q + 32'd1;
        end else if (mret_req) begin
          state_d      = FLUSH;
          cnt_d        = FLUSH_RELOAD;
          branch_v_d   = 1'b1;
          branch_adr_d = mepc_q_i;
          flush_d      = 1'b1;
          busy_d       = 1'b1;
        end
      end
      FLUSH: begin
        // Requests arriving here are intentionally dropped, not queued.
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          flush_d = 1'b0;
          busy_d  = 1'b0;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          flush_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        flush_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; asynchronous reset clears everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      exception_q  <= 1'b0;
      mcause_q     <= '0;
      mtval_q      <= '0;
      mepc_q       <= '0;
      branch_v_q   <= 1'b0;
      branch_adr_q <= '0;
      flush_q      <= 1'b0;
      busy_q       <= 1'b0;
      trap_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      exception_q  <= exception_d;
      mcause_q     <= mcause_d;
      mtval_q      <= mtval_d;
      mepc_q       <= mepc_d;
      branch_v_q   <= branch_v_d;
      branch_adr_q <= branch_adr_d;
      flush_q      <= flush_d;
      busy_q       <= busy_d;
      trap_cnt_q   <= trap_cnt_d;
    end
  end

  assign exception_o  = exception_q;
  assign mcause_o     = mcause_q;
  assign mtval_o      = mtval_q;
  assign mepc_o       = mepc_q;
  assign branch_v_o   = branch_v_q;
  assign branch_adr_o = branch_adr_q;
  assign flush_o      = flush_q;
  assign busy_o       = busy_q;
  assign trap_cnt_o   = trap_cnt_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed checks of trap_ctrl with FLUSH_CYCLES=2, XLEN=32.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        instr_v_i;
  logic [31:0] pc_i;
  logic [31:0] instr_i;
  logic [31:0] badaddr_i;
  logic        instr_misaligned_i, illegal_i, ebreak_i, ecall_i;
  logic        load_misaligned_i, store_misaligned_i, mret_i;
  logic [31:0] mtvec_q_i, mepc_q_i;
  logic        exception_o, branch_v_o, flush_o, busy_o;
  logic [31:0] mcause_o, mtval_o, mepc_o, branch_adr_o, trap_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trap_ctrl #(.XLEN(32), .FLUSH_CYCLES(2)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .instr_v_i          (instr_v_i),
    .pc_i               (pc_i),
    .instr_i            (instr_i),
    .badaddr_i          (badaddr_i),
    .instr_misaligned_i (instr_misaligned_i),
    .illegal_i          (illegal_i),
    .ebreak_i           (ebreak_i),
    .ecall_i            (ecall_i),
    .load_misaligned_i  (load_misaligned_i),
    .store_misaligned_i (store_misaligned_i),
    .mret_i             (mret_i),
    .mtvec_q_i          (mtvec_q_i),
    .mepc_q_i           (mepc_q_i),
    .exception_o        (exception_o),
    .mcause_o           (mcause_o),
    .mtval_o            (mtval_o),
    .mepc_o             (mepc_o),
    .branch_v_o         (branch_v_o),
    .branch_adr_o       (branch_adr_o),
    .flush_o            (flush_o),
    .busy_o             (busy_o),
    .trap_cnt_o         (trap_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    instr_v_i = 0; instr_misaligned_i = 0; illegal_i = 0; ebreak_i = 0;
    ecall_i = 0; load_misaligned_i = 0; store_misaligned_i = 0; mret_i = 0;
  endtask

  // Advance one full cycle: rising edge, then back to the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset_n = 0;
    clear_inputs();
    pc_i = 0; instr_i = 0; badaddr_i = 0; mtvec_q_i = 0; mepc_q_i = 0;
    step();
    // Reset state
    chk("rst_exception", 32'(exception_o), 32'd0);
    chk("rst_flush",     32'(flush_o),     32'd0);
    chk("rst_busy",      32'(busy_o),      32'd0);
    chk("rst_branch_v",  32'(branch_v_o),  32'd0);
    chk("rst_trap_cnt",  trap_cnt_o,       32'd0);
    chk("rst_mcause",    mcause_o,         32'd0);
    reset_n = 1;
    step();

    // Illegal instruction trap
    $display("txn: illegal trap pc=0x100");
    instr_v_i = 1; illegal_i = 1; pc_i = 32'h100; instr_i = 32'hFFFF_FFFF; mtvec_q_i = 32'h803;
    step();
    chk("ill_exception",  32'(exception_o), 32'd1);
    chk("ill_branch_v",   32'(branch_v_o),  32'd1);
    chk("ill_branch_adr", branch_adr_o,     32'h800);
    chk("ill_mcause",     mcause_o,         32'd2);
    chk("ill_mtval",      mtval_o,          32'hFFFF_FFFF);
    chk("ill_mepc",       mepc_o,           32'h100);
    chk("ill_flush1",     32'(flush_o),     32'd1);
    chk("ill_busy1",      32'(busy_o),      32'd1);
    chk("ill_trap_cnt",   trap_cnt_o,       32'd1);
    // Second trap during FLUSH must be dropped
    $display("txn: ecall during flush (dropped)");
    clear_inputs();
    instr_v_i = 1; ecall_i = 1; pc_i = 32'h200;
    step();
    chk("drop_exception", 32'(exception_o), 32'd0);
    chk("drop_branch_v",  32'(branch_v_o),  32'd0);
    chk("ill_flush2",     32'(flush_o),     32'd1);
    chk("drop_mcause",    mcause_o,         32'd2);
    chk("drop_mepc",      mepc_o,           32'h100);
    chk("drop_trap_cnt",  trap_cnt_o,       32'd1);
    clear_inputs();
    step();
    chk("ill_flush_end",  32'(flush_o),     32'd0);
    chk("ill_busy_end",   32'(busy_o),      32'd0);

    // Trap in the cycle state is back in IDLE; ecall beats load_misaligned
    $display("txn: ecall+load_misaligned pc=0x300 on return to idle");
    instr_v_i = 1; ecall_i = 1; load_misaligned_i = 1; badaddr_i = 32'h33; pc_i = 32'h300;
    step();
    clear_inputs();
    chk("b2b_exception", 32'(exception_o), 32'd1);
    chk("b2b_mcause",    mcause_o,         32'd11);
    chk("b2b_mtval",     mtval_o,          32'd0);
    chk("b2b_mepc",      mepc_o,           32'h300);
    chk("b2b_trap_cnt",  trap_cnt_o,       32'd2);
    step();
    step();
    chk("b2b_idle", 32'(busy_o), 32'd0);

    // MRET
    $display("txn: mret mepc=0x2000");
    instr_v_i = 1; mret_i = 1; mepc_q_i = 32'h2000;
    step();
    clear_inputs();
    chk("mret_branch_v",   32'(branch_v_o),  32'd1);
    chk("mret_branch_adr", branch_adr_o,     32'h2000);
    chk("mret_exception",  32'(exception_o), 32'd0);
    chk("mret_flush",      32'(flush_o),     32'd1);
    chk("mret_trap_cnt",   trap_cnt_o,       32'd2);
    chk("mret_mcause",     mcause_o,         32'd11);
    step();
    chk("mret_flush2",  32'(flush_o),    32'd1);
    chk("mret_branch2", 32'(branch_v_o), 32'd0);
    step();

    // ebreak together with mret: trap wins
    $display("txn: ebreak+mret pc=0x400");
    instr_v_i = 1; ebreak_i = 1; mret_i = 1; pc_i = 32'h400; mtvec_q_i = 32'h1001; badaddr_i = 32'h77;
    step();
    clear_inputs();
    chk("ebm_exception",  32'(exception_o), 32'd1);
    chk("ebm_branch_adr", branch_adr_o,     32'h1000);
    chk("ebm_mcause",     mcause_o,         32'd3);
    chk("ebm_mtval",      mtval_o,          32'd0);
    chk("ebm_mepc",       mepc_o,           32'h400);
    chk("ebm_trap_cnt",   trap_cnt_o,       32'd3);
    step();
    step();

    // instr_v_i low masks everything
    $display("txn: masked illegal+mret");
    instr_v_i = 0; illegal_i = 1; mret_i = 1;
    step();
    clear_inputs();
    chk("mask_busy",     32'(busy_o),     32'd0);
    chk("mask_branch_v", 32'(branch_v_o), 32'd0);
    chk("mask_trap_cnt", trap_cnt_o,      32'd3);

    // store misaligned alone
    $display("txn: store_misaligned badaddr=0x55");
    instr_v_i = 1; store_misaligned_i = 1; badaddr_i = 32'h55; pc_i = 32'h500;
    step();
    clear_inputs();
    chk("st_mcause",   mcause_o,   32'd6);
    chk("st_mtval",    mtval_o,    32'h55);
    chk("st_trap_cnt", trap_cnt_o, 32'd4);
    step();
    step();

    // instr_misaligned beats illegal
    $display("txn: instr_misaligned+illegal badaddr=0x66");
    instr_v_i = 1; instr_misaligned_i = 1; illegal_i = 1; badaddr_i = 32'h66; instr_i = 32'h1234;
    step();
    clear_inputs();
    chk("im_mcause",   mcause_o,   32'd0);
    chk("im_mtval",    mtval_o,    32'h66);
    chk("im_trap_cnt", trap_cnt_o, 32'd5);
    // Reset during the first FLUSH cycle
    $display("txn: async reset mid-flush");
    #2 reset_n = 0;
    #1;
    chk("arst_flush",    32'(flush_o),     32'd0);
    chk("arst_busy",     32'(busy_o),      32'd0);
    chk("arst_exc",      32'(exception_o), 32'd0);
    chk("arst_trap_cnt", trap_cnt_o,       32'd0);
    @(negedge clk);
    reset_n = 1;
    step();
    instr_v_i = 1; load_misaligned_i = 1; badaddr_i = 32'h99; pc_i = 32'h600;
    step();
    clear_inputs();
    chk("post_rst_exc",      32'(exception_o), 32'd1);
    chk("post_rst_mcause",   mcause_o,         32'd4);
    chk("post_rst_mtval",    mtval_o,          32'h99);
    chk("post_rst_trap_cnt", trap_cnt_o,       32'd1);
    step();
    step();

    // Counter wrap
    $display("txn: trap counter wrap");
    force dut.trap_cnt_q = 32'hFFFF_FFFF;
    step();
    release dut.trap_cnt_q;
    chk("wrap_pre", trap_cnt_o, 32'hFFFF_FFFF);
    instr_v_i = 1; ecall_i = 1; pc_i = 32'h700;
    step();
    clear_inputs();
    chk("wrap_exc", 32'(exception_o), 32'd1);
    chk("wrap_cnt", trap_cnt_o,       32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
